// File: rtl/bank_mem_pkg.sv
// Shared constants and types for the four-bank word memory with fixed read latency.
package bank_mem_pkg;
    localparam int BANK_CNT      = 4;
    localparam int BANK_BUSY_CYC = 4;
    localparam int RD_LAT        = 2;

    typedef logic [1:0] bank_idx_t;
endpackage

// File: rtl/mem_bank.sv
// One memory bank: word storage slice, occupancy down-counter and a two-stage read return pipe.
module mem_bank
    import bank_mem_pkg::*;
#(
    parameter int ROW_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [ROW_W-1:0] row,
    input  logic [15:0]      data_in,
    output logic             busy,
    output logic [15:0]      rd_data
);
    logic [15:0] mem [2**ROW_W];
    logic [1:0]  cnt;
    logic        accept;
    logic        vld_p0;
    logic        vld_p1;
    logic [15:0] data_p0;
    logic [15:0] data_p1;

    assign busy   = (cnt != 2'd0);
    assign accept = en & ~busy & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 2'd0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (accept)
                cnt <= 2'(BANK_BUSY_CYC - 1);
            else if (busy)
                cnt <= cnt - 2'd1;
            vld_p0 <= accept & ~wr;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p0: storage access at acceptance; stage p1: return register.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr)
                mem[row] <= data_in;
            else
                data_p0 <= mem[row];
        end
        data_p1 <= data_p0;
    end

    assign rd_data = vld_p1 ? data_p1 : 16'h0000;
endmodule

// File: rtl/bank_mem_resp.sv
// Four-bank interleaved word memory with stall/err handshake and two-cycle read return.
// Optional BANK_MEM_DUMP_EN: createdump prints the full storage as hex words (simulation only).
module bank_mem_resp
    import bank_mem_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    input  logic        createdump,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);
    localparam int ROW_W = ADDR_BITS - 3;

    bank_idx_t   bank;
    logic        req;
    logic        legal;
    logic [15:0] bank_data [BANK_CNT];
    logic        unused_bits;

    assign bank  = addr[2:1];
    assign req   = rd | wr;
    assign err   = (rd & wr) | (req & addr[0]);
    assign legal = req & ~err;
    assign stall = legal & busy[bank];

    for (genvar b = 0; b < BANK_CNT; b++) begin : gen_bank
        mem_bank #(
            .ROW_W(ROW_W)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .en     (legal && (bank == bank_idx_t'(b))),
            .wr     (wr),
            .row    (addr[ADDR_BITS-1:3]),
            .data_in(data_in),
            .busy   (busy[b]),
            .rd_data(bank_data[b])
        );
    end

    // Only one bank can be returning in any cycle, so OR-ing the returns is safe.
    always_comb begin
        data_out = 16'h0000;
        for (int b = 0; b < BANK_CNT; b++)
            data_out = data_out | bank_data[b];
    end

`ifdef BANK_MEM_DUMP_EN
    assign unused_bits = ^addr;

    always @(posedge clk) begin
        if (createdump) begin
            logic [15:0] w;
            for (int i = 0; i < 2**(ADDR_BITS-1); i++) begin
                case (i % 4)
                    0:       w = gen_bank[0].u_bank.mem[i/4];
                    1:       w = gen_bank[1].u_bank.mem[i/4];
                    2:       w = gen_bank[2].u_bank.mem[i/4];
                    default: w = gen_bank[3].u_bank.mem[i/4];
                endcase
                $display("%h", w);
            end
        end
    end
`else
    assign unused_bits = ^{createdump, addr};
`endif
endmodule

// File: tb/tb_bank_mem_resp.sv
// Randomized and directed bench for bank_mem_resp against a cycle-indexed reference model.
module tb_bank_mem_resp;
    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic        createdump;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: word contents by word index, per-bank next-free cycle, returns by cycle.
    logic [15:0] mem_m [int];
    int          free_at [4];
    logic [15:0] ret_m [int];
    logic [15:0] pool [16];

    bank_mem_resp #(.ADDR_BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data_in   (data_in),
        .wr        (wr),
        .rd        (rd),
        .createdump(createdump),
        .data_out  (data_out),
        .stall     (stall),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, check outputs mid-cycle, advance the model.
    task automatic step(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output logic acc);
        logic [3:0]  eb;
        logic        e_err;
        logic        e_stall;
        logic [15:0] e_dout;
        int          b;
        rd = r; wr = w; addr = a; data_in = d;
        @(negedge clk);
        b = int'(a[2:1]);
        for (int i = 0; i < 4; i++) eb[i] = (cyc < free_at[i]);
        e_err   = (r & w) | ((r | w) & a[0]);
        e_stall = (r | w) & ~e_err & eb[b];
        e_dout  = ret_m.exists(cyc) ? ret_m[cyc] : 16'h0000;
        check("err", {31'b0, err}, {31'b0, e_err});
        check("stall", {31'b0, stall}, {31'b0, e_stall});
        check("busy", {28'b0, busy}, {28'b0, eb});
        check("data_out", {16'b0, data_out}, {16'b0, e_dout});
        acc = (r | w) & ~e_err & ~eb[b];
        if (acc) begin
            free_at[b] = cyc + 4;
            if (w) mem_m[int'(a[15:1])] = d;
            else   ret_m[cyc + 2] = mem_m[int'(a[15:1])];
        end
        if (ret_m.exists(cyc)) ret_m.delete(cyc);
        @(posedge clk);
        #1;
        cyc++;
        rd = 1'b0; wr = 1'b0; createdump = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, acc);
    endtask

    // Write until accepted, holding the request through stalls.
    task automatic put(input logic [15:0] a, input logic [15:0] d);
        logic acc;
        int   tries = 0;
        do begin
            step(1'b0, 1'b1, a, d, acc);
            tries++;
        end while (!acc && tries < 8);
        check("put_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic do_reset();
        rd = 1'b0; wr = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_busy_async", {28'b0, busy}, 32'd0);
        check("rst_dout_async", {16'b0, data_out}, 32'd0);
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        ret_m.delete();
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        logic        acc;
        int          n;
        logic [31:0] rnd;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0; createdump = 1'b0;
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {28'b0, busy}, 32'd0);
        check("reset_dout", {16'b0, data_out}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Write-then-read after bank recovers.
        step(1'b0, 1'b1, 16'h0010, 16'hBEEF, acc);
        check("beef_wr_acc", {31'b0, acc}, 32'd1);
        idle(3);
        step(1'b1, 1'b0, 16'h0010, 16'h0000, acc);
        check("beef_rd_acc", {31'b0, acc}, 32'd1);
        idle(1);
        check("beef_value", {16'b0, data_out}, 32'h0000BEEF);
        idle(3);

        put(16'h0000, 16'h1111);
        put(16'h0002, 16'h2222);
        put(16'h0004, 16'h3333);
        put(16'h0006, 16'h4444);
        put(16'h0008, 16'h5555);
        idle(4);

        // Same-bank read held through stalls.
        step(1'b1, 1'b0, 16'h0000, 16'h0000, acc);
        n = 0;
        do begin
            step(1'b1, 1'b0, 16'h0008, 16'h0000, acc);
            n++;
        end while (!acc && n < 8);
        check("same_bank_tries", n, 32'd4);
        idle(4);

        // Four banks back to back.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'(2 * i), 16'h0000, acc);
            check("interleave_acc", {31'b0, acc}, 32'd1);
        end
        idle(4);

        // Illegal requests.
        step(1'b1, 1'b1, 16'h0020, 16'h0000, acc);
        step(1'b1, 1'b0, 16'h0021, 16'h0000, acc);
        check("illegal_busy", {28'b0, busy}, 32'd0);
        idle(2);

        // Reset mid-read, storage survives.
        step(1'b1, 1'b0, 16'h0002, 16'h0000, acc);
        do_reset();
        step(1'b1, 1'b0, 16'h0002, 16'h0000, acc);
        check("post_reset_acc", {31'b0, acc}, 32'd1);
        idle(4);

        // Randomized traffic over a pre-written address pool.
        for (int i = 0; i < 16; i++) begin
            rnd = $urandom;
            pool[i] = rnd[15:0] & 16'hFFFE;
            put(pool[i], rnd[31:16]);
        end
        idle(4);
        for (int t = 0; t < 600; t++) begin
            rnd = $urandom;
            if (rnd[7:0] == 8'd3) begin
                do_reset();
            end else begin
                createdump = (rnd[15:8] == 8'd7);
                case (rnd[17:16])
                    2'd0: step(1'b0, 1'b0, pool[rnd[23:20]], rnd[31:16], acc);
                    2'd1: step(1'b1, 1'b0, pool[rnd[23:20]], 16'h0000, acc);
                    2'd2: step(1'b0, 1'b1, pool[rnd[23:20]], rnd[31:16], acc);
                    default: begin
                        if (rnd[18]) step(1'b1, 1'b1, pool[rnd[23:20]], 16'h0000, acc);
                        else         step(rnd[19], ~rnd[19], pool[rnd[23:20]] | 16'h0001, 16'h0000, acc);
                    end
                endcase
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
